// File: rtl/paddle_motion_ctrl_if.sv
// Joystick-to-paddle bundle: latched axis sample in, paddle position/status out.
// Latency: none (wires only); the controller registers everything it drives.
// Backpressure: none; sample_valid is a one-cycle strobe that is always accepted.
//
// Signals:
//   sample, sample_valid      joystick reader -> controller
//   y, moving, dir_up, stale  controller -> renderer / status
interface paddle_motion_ctrl_if #(
    parameter int ADC_W = 10,
    parameter int POS_W = 10
);
    logic [ADC_W-1:0] sample;
    logic             sample_valid;
    logic [POS_W-1:0] y;
    logic             moving;
    logic             dir_up;
    logic             stale;

    // Joystick side drives the sample and observes the paddle.
    modport master (
        output sample, sample_valid,
        input  y, moving, dir_up, stale
    );

    // Controller side.
    modport slave (
        input  sample, sample_valid,
        output y, moving, dir_up, stale
    );
endinterface

// File: rtl/paddle_motion_ctrl.sv
// Per-player paddle position controller: joystick zone -> per-frame saturating move.
// Latency: y updates 2 clk50M edges after frame_tick is first sampled high.
// Backpressure: none; samples are always accepted, one update per frame edge.
//
// Ports:
//   clk50M      system clock
//   reset_n     async active-low reset (asserts immediately, released synchronously)
//   frame_tick  async VGA end-of-frame level; each rising edge is one frame
//   bus         slave side of paddle_motion_ctrl_if (sample in, y/moving/dir_up/stale out)
module paddle_motion_ctrl #(
    parameter int               ADC_W        = 10,
    parameter int               POS_W        = 10,
    parameter int               Y_MIN        = 0,
    parameter int               Y_MAX        = 480,
    parameter int               PADDLE_H     = 50,
    parameter int               Y_INIT       = 40,
    parameter logic [ADC_W-1:0] HI_FAST      = 'h300,
    parameter logic [ADC_W-1:0] HI_SLOW      = 'h220,
    parameter logic [ADC_W-1:0] LO_SLOW      = 'h180,
    parameter logic [ADC_W-1:0] LO_FAST      = 'h0F0,
    parameter int               SLOW_STEP    = 1,
    parameter int               FAST_STEP    = 3,
    parameter int               ACCEL_EN     = 0,
    parameter int               ACCEL_FRAMES = 8,
    parameter int               STALE_FRAMES = 4,
    parameter int               INVERT       = 0
) (
    input  logic                 clk50M,
    input  logic                 reset_n,
    input  logic                 frame_tick,
    paddle_motion_ctrl_if.slave  bus
);

    localparam int PW    = POS_W + 2;
    localparam int SPD_W = $clog2(FAST_STEP + 2);
    localparam int AC_W  = (ACCEL_FRAMES < 1) ? 1 : $clog2(ACCEL_FRAMES + 1);
    localparam int ST_W  = (STALE_FRAMES < 1) ? 1 : $clog2(STALE_FRAMES + 1);
    localparam int MID_I = (int'(LO_SLOW) + int'(HI_SLOW)) / 2;

    localparam logic [SPD_W-1:0]     SLOW_SPD   = SPD_W'(SLOW_STEP);
    localparam logic [SPD_W-1:0]     FAST_SPD   = SPD_W'(FAST_STEP);
    localparam logic [AC_W-1:0]      AC_MAX     = AC_W'(ACCEL_FRAMES);
    localparam logic [ST_W-1:0]      ST_MAX     = ST_W'(STALE_FRAMES);
    localparam logic [ADC_W-1:0]     SAMPLE_MID = ADC_W'(MID_I);
    localparam logic [POS_W-1:0]     Y_RST      = POS_W'(Y_INIT);
    localparam logic signed [PW-1:0] Y_LO       = PW'(Y_MIN);
    localparam logic signed [PW-1:0] Y_HI       = PW'(Y_MAX - PADDLE_H);
    localparam logic                 INV        = (INVERT != 0);
    localparam logic                 ACC        = (ACCEL_EN != 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SLOW,
        S_RAMP
    } acc_state_t;

    // ------------------------------------------------------------------
    // Reset: asserts asynchronously, releases on the clock so every flop
    // below leaves reset in the same cycle.
    // ------------------------------------------------------------------
    logic rst_s1_q;
    logic rst_n_q;

    always_ff @(posedge clk50M or negedge reset_n) begin
        if (!reset_n) begin
            rst_s1_q <= 1'b0;
            rst_n_q  <= 1'b0;
        end else begin
            rst_s1_q <= 1'b1;
            rst_n_q  <= rst_s1_q;
        end
    end

    // ------------------------------------------------------------------
    // Frame edge: two-flop synchroniser plus one flop for edge detect.
    // A long high level yields exactly one tick.
    // ------------------------------------------------------------------
    logic fs1_q, fs2_q, fs3_q;
    logic tick;

    always_ff @(posedge clk50M or negedge rst_n_q) begin
        if (!rst_n_q) begin
            fs1_q <= 1'b0;
            fs2_q <= 1'b0;
            fs3_q <= 1'b0;
        end else begin
            fs1_q <= frame_tick;
            fs2_q <= fs1_q;
            fs3_q <= fs2_q;
        end
    end

    assign tick = fs2_q & ~fs3_q;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [ADC_W-1:0] sample_q;
    logic [ST_W-1:0]  st_cnt_q;
    logic             stale_q;
    logic [POS_W-1:0] y_q;
    logic             moving_q;
    logic             dir_up_q;
    acc_state_t       state_q;
    logic             adir_q;
    logic [AC_W-1:0]  acnt_q;
    logic [SPD_W-1:0] aspd_q;

    // ------------------------------------------------------------------
    // Zone decode. A stale joystick is treated as centred so a dead
    // reader never drives the paddle into a wall.
    // ------------------------------------------------------------------
    logic zone_nz;
    logic zone_neg;
    logic zone_fast;
    logic raw_neg;

    always_comb begin
        raw_neg   = 1'b0;
        zone_nz   = 1'b1;
        zone_fast = 1'b0;
        if (sample_q > HI_FAST) begin
            raw_neg   = 1'b1;
            zone_fast = 1'b1;
        end else if (sample_q > HI_SLOW) begin
            raw_neg   = 1'b1;
        end else if (sample_q > LO_SLOW) begin
            zone_nz   = 1'b0;
        end else if (sample_q > LO_FAST) begin
            raw_neg   = 1'b0;
        end else begin
            zone_fast = 1'b1;
        end
        if (stale_q) begin
            zone_nz = 1'b0;
        end
        zone_neg = raw_neg ^ INV;
    end

    // ------------------------------------------------------------------
    // Acceleration next state. The speed computed here is the one applied
    // in the same frame update.
    // ------------------------------------------------------------------
    acc_state_t       state_d;
    logic             adir_d;
    logic [AC_W-1:0]  acnt_d;
    logic [SPD_W-1:0] aspd_d;
    logic [AC_W-1:0]  acnt_inc;

    always_comb begin
        state_d  = state_q;
        adir_d   = adir_q;
        acnt_d   = acnt_q;
        aspd_d   = aspd_q;
        acnt_inc = acnt_q + AC_W'(1);
        if (!zone_nz || (state_q != S_IDLE && zone_neg != adir_q)) begin
            // Centred stick or reversal: stop and start over next frame.
            state_d = S_IDLE;
            acnt_d  = '0;
            aspd_d  = '0;
        end else if (state_q == S_IDLE) begin
            state_d = zone_fast ? S_RAMP : S_SLOW;
            adir_d  = zone_neg;
            acnt_d  = '0;
            aspd_d  = SLOW_SPD;
        end else if (zone_fast) begin
            state_d = S_RAMP;
            if (acnt_inc == AC_MAX) begin
                acnt_d = '0;
                aspd_d = (aspd_q >= FAST_SPD) ? FAST_SPD : aspd_q + SPD_W'(1);
            end else begin
                acnt_d = acnt_inc;
            end
        end else begin
            state_d = S_SLOW;
            acnt_d  = '0;
            aspd_d  = SLOW_SPD;
        end
    end

    // ------------------------------------------------------------------
    // Position update with saturation (computed two bits wider so the
    // signed under/overflow is visible before clamping).
    // ------------------------------------------------------------------
    logic [SPD_W-1:0]     fix_spd;
    logic [SPD_W-1:0]     spd;
    logic signed [PW-1:0] y_ext;
    logic signed [PW-1:0] spd_ext;
    logic signed [PW-1:0] nxt;
    logic signed [PW-1:0] nxt_sat;
    logic [POS_W-1:0]     y_d;
    logic                 moving_d;

    always_comb begin
        fix_spd = zone_fast ? FAST_SPD : SLOW_SPD;
        if (!zone_nz) begin
            fix_spd = '0;
        end
        spd     = ACC ? aspd_d : fix_spd;
        y_ext   = $signed({2'b00, y_q});
        spd_ext = $signed({{(PW - SPD_W){1'b0}}, spd});
        nxt     = zone_neg ? (y_ext - spd_ext) : (y_ext + spd_ext);
        nxt_sat = nxt;
        if (nxt < Y_LO) begin
            nxt_sat = Y_LO;
        end else if (nxt > Y_HI) begin
            nxt_sat = Y_HI;
        end
        y_d      = nxt_sat[POS_W-1:0];
        moving_d = (y_d != y_q);
    end

    // ------------------------------------------------------------------
    // Stale counter next value (saturating).
    // ------------------------------------------------------------------
    logic [ST_W-1:0] st_cnt_d;

    always_comb begin
        st_cnt_d = st_cnt_q;
        if (st_cnt_q != ST_MAX) begin
            st_cnt_d = st_cnt_q + ST_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Registers. The frame update reads the sample/stale values held
    // before this edge, so a sample arriving with the tick applies from
    // the following frame.
    // ------------------------------------------------------------------
    always_ff @(posedge clk50M or negedge rst_n_q) begin
        if (!rst_n_q) begin
            sample_q <= SAMPLE_MID;
            st_cnt_q <= '0;
            stale_q  <= 1'b1;
            y_q      <= Y_RST;
            moving_q <= 1'b0;
            dir_up_q <= 1'b0;
            state_q  <= S_IDLE;
            adir_q   <= 1'b0;
            acnt_q   <= '0;
            aspd_q   <= '0;
        end else begin
            if (tick) begin
                y_q      <= y_d;
                moving_q <= moving_d;
                if (moving_d) begin
                    dir_up_q <= zone_neg;
                end
                state_q <= state_d;
                adir_q  <= adir_d;
                acnt_q  <= acnt_d;
                aspd_q  <= aspd_d;
            end
            if (bus.sample_valid) begin
                sample_q <= bus.sample;
                st_cnt_q <= '0;
                stale_q  <= 1'b0;
            end else if (tick) begin
                st_cnt_q <= st_cnt_d;
                if (st_cnt_d == ST_MAX) begin
                    stale_q <= 1'b1;
                end
            end
        end
    end

    assign bus.y      = y_q;
    assign bus.moving = moving_q;
    assign bus.dir_up = dir_up_q;
    assign bus.stale  = stale_q;

endmodule

// File: tb/tb_paddle_motion_ctrl.sv
// Directed bench for paddle_motion_ctrl: fixed-speed instance (u_a) and
// accelerating instance (u_b, ACCEL_FRAMES=2) driven by the same stimulus.
// Expected positions are hand-computed from the frame sequence.
`timescale 1ns/1ps
module tb_paddle_motion_ctrl;

    logic       clk50M = 1'b0;
    logic       reset_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic [9:0] smp_r = 10'h200;
    logic       sv_r = 1'b0;

    int n_chk  = 0;
    int n_pass = 0;

    always #10 clk50M = ~clk50M;

    paddle_motion_ctrl_if #(.ADC_W(10), .POS_W(10)) ifa ();
    paddle_motion_ctrl_if #(.ADC_W(10), .POS_W(10)) ifb ();

    assign ifa.sample       = smp_r;
    assign ifa.sample_valid = sv_r;
    assign ifb.sample       = smp_r;
    assign ifb.sample_valid = sv_r;

    paddle_motion_ctrl u_a (
        .clk50M     (clk50M),
        .reset_n    (reset_n),
        .frame_tick (frame_tick),
        .bus        (ifa)
    );

    paddle_motion_ctrl #(.ACCEL_EN(1), .ACCEL_FRAMES(2)) u_b (
        .clk50M     (clk50M),
        .reset_n    (reset_n),
        .frame_tick (frame_tick),
        .bus        (ifb)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end else begin
            n_pass++;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk50M);
        #1 reset_n = 1'b1;
        repeat (4) @(posedge clk50M);
        #1;
    endtask

    // One frame: optional sample strobe ahead of the frame edge, or (coinc)
    // a strobe landing on the same clock as the internal tick.
    task automatic frame(input bit feed, input logic [9:0] smp, input bit coinc);
        if (feed && !coinc) begin
            @(posedge clk50M); #1;
            smp_r = smp;
            sv_r  = 1'b1;
            @(posedge clk50M); #1;
            sv_r  = 1'b0;
        end
        @(posedge clk50M); #1;
        frame_tick = 1'b1;
        @(posedge clk50M);          // edge k
        @(posedge clk50M); #1;      // edge k+1: tick now high
        if (coinc) begin
            smp_r = smp;
            sv_r  = 1'b1;
        end
        @(posedge clk50M); #1;      // edge k+2: update done
        sv_r       = 1'b0;
        frame_tick = 1'b0;
        repeat (3) @(posedge clk50M);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int exp_b[7];
        exp_b = '{41, 42, 44, 46, 49, 52, 55};

        // ---- 1: reset values and dead zone / stale -------------------
        do_reset();
        chk("rst_y",      ifa.y, 40);
        chk("rst_moving", ifa.moving, 0);
        chk("rst_dir_up", ifa.dir_up, 0);
        chk("rst_stale",  ifa.stale, 1);
        chk("rst_y_b",    ifb.y, 40);
        frame(1'b1, 10'h200, 1'b0);
        chk("dead_y",      ifa.y, 40);
        chk("dead_stale0", ifa.stale, 0);
        frame(1'b0, 10'h200, 1'b0);
        frame(1'b0, 10'h200, 1'b0);
        chk("stale_t3", ifa.stale, 0);
        frame(1'b0, 10'h200, 1'b0);
        chk("stale_t4", ifa.stale, 1);
        frame(1'b0, 10'h200, 1'b0);
        chk("dead_y5",      ifa.y, 40);
        chk("dead_moving5", ifa.moving, 0);

        // ---- 2: fast/slow negative, top clamp ------------------------
        frame(1'b1, 10'h3F0, 1'b0);
        chk("fneg_37", ifa.y, 37);
        chk("fneg_dir", ifa.dir_up, 1);
        chk("fneg_mov", ifa.moving, 1);
        frame(1'b1, 10'h3F0, 1'b0);
        chk("fneg_34", ifa.y, 34);
        frame(1'b1, 10'h3F0, 1'b0);
        chk("fneg_31", ifa.y, 31);
        frame(1'b1, 10'h250, 1'b0);
        chk("sneg_30", ifa.y, 30);
        frame(1'b1, 10'h250, 1'b0);
        for (int i = 0; i < 9; i++) frame(1'b1, 10'h3F0, 1'b0);
        chk("fneg_2", ifa.y, 2);
        frame(1'b1, 10'h3F0, 1'b0);
        chk("clamp_top_y",   ifa.y, 0);
        chk("clamp_top_mov", ifa.moving, 1);
        frame(1'b1, 10'h3F0, 1'b0);
        chk("held_top_y",   ifa.y, 0);
        chk("held_top_mov", ifa.moving, 0);
        chk("held_top_dir", ifa.dir_up, 1);

        // ---- 3: fast/slow positive, bottom clamp ---------------------
        for (int i = 0; i < 142; i++) frame(1'b1, 10'h010, 1'b0);
        chk("fpos_426", ifa.y, 426);
        frame(1'b1, 10'h100, 1'b0);
        frame(1'b1, 10'h100, 1'b0);
        chk("spos_428", ifa.y, 428);
        chk("spos_dir", ifa.dir_up, 0);
        frame(1'b1, 10'h010, 1'b0);
        chk("clamp_bot_y",   ifa.y, 430);
        chk("clamp_bot_mov", ifa.moving, 1);
        frame(1'b1, 10'h010, 1'b0);
        chk("held_bot_y",   ifa.y, 430);
        chk("held_bot_mov", ifa.moving, 0);

        // ---- 4: synchroniser latency, long high, mid-frame reset -----
        @(posedge clk50M); #1;
        smp_r = 10'h3F0;
        sv_r  = 1'b1;
        @(posedge clk50M); #1;
        sv_r  = 1'b0;
        frame_tick = 1'b1;
        @(posedge clk50M); #1;      // edge k
        chk("lat_k", ifa.y, 430);
        @(posedge clk50M); #1;      // edge k+1
        chk("lat_k1", ifa.y, 430);
        @(posedge clk50M); #1;      // edge k+2
        chk("lat_k2", ifa.y, 427);
        repeat (97) @(posedge clk50M);
        #1;
        chk("long_high_once", ifa.y, 427);
        frame_tick = 1'b0;
        repeat (4) @(posedge clk50M);
        #1 frame_tick = 1'b1;
        @(posedge clk50M); #1;
        reset_n = 1'b0;
        #2;
        chk("midrst_y", ifa.y, 40);
        frame_tick = 1'b0;
        repeat (3) @(posedge clk50M);
        #1 reset_n = 1'b1;
        repeat (8) @(posedge clk50M);
        #1;
        chk("midrst_after_y",   ifa.y, 40);
        chk("midrst_after_mov", ifa.moving, 0);
        chk("midrst_stale",     ifa.stale, 1);

        // ---- 6: sample coinciding with tick --------------------------
        frame(1'b1, 10'h200, 1'b0);
        chk("co_pre_y",     ifa.y, 40);
        chk("co_pre_stale", ifa.stale, 0);
        frame(1'b1, 10'h3F0, 1'b1);
        chk("co_y",     ifa.y, 40);
        chk("co_mov",   ifa.moving, 0);
        frame(1'b0, 10'h3F0, 1'b0);
        chk("co_next_y",     ifa.y, 37);
        chk("co_next_stale", ifa.stale, 0);
        chk("co_next_mov",   ifa.moving, 1);

        // ---- 5: acceleration on u_b ----------------------------------
        do_reset();
        chk("acc_rst_y", ifb.y, 40);
        for (int i = 0; i < 7; i++) begin
            frame(1'b1, 10'h010, 1'b0);
            chk($sformatf("acc_y%0d", i), ifb.y, exp_b[i]);
        end
        frame(1'b1, 10'h200, 1'b0);
        chk("acc_dead_y",   ifb.y, 55);
        chk("acc_dead_mov", ifb.moving, 0);
        frame(1'b1, 10'h3F0, 1'b0);
        chk("acc_rev_y",   ifb.y, 54);
        chk("acc_rev_dir", ifb.dir_up, 1);
        frame(1'b1, 10'h3F0, 1'b0);
        chk("acc_rev_y2", ifb.y, 53);
        frame(1'b1, 10'h3F0, 1'b0);
        chk("acc_rev_y3", ifb.y, 51);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
